// File: rtl/rv_lsu_align_if.sv
// rv_lsu_align_if: CPU request/response and data-memory beat signals of the LSU alignment unit.
// The slave modport is the alignment unit's view; master is the CPU/memory side.
interface rv_lsu_align_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) ();
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_byte_enable;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_resp;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_byte_enable, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: turns one byte/half/word/dword request into aligned memory beats and returns extended load data.
// Define MISALIGNED_SPLIT_EN to service misaligned accesses (two beats when crossing a beat boundary).
module rv_lsu_align #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    rv_lsu_align_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t            state;
    state_t            state_next;

    logic              we_q;
    logic              uns_q;
    logic              err_q;
    logic              split_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] base_q;
    logic [2*XLEN-1:0] wdata_q;
    logic [2*NB-1:0]   be_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   rdata_q;

    logic              accept;
    logic [OFF_W-1:0]  req_off;
    logic [3:0]        req_bytes;
    logic              req_aligned;
    logic              req_cross;
    logic              req_bad_size;
    logic              req_illegal;
    logic [NB-1:0]     req_mask;
    logic [2*XLEN-1:0] req_wide_wdata;
    logic [2*NB-1:0]   req_wide_be;

    logic [2*XLEN-1:0] load_shifted;
    logic [XLEN-1:0]   load_raw;
    logic [6:0]        load_nbits;
    logic [XLEN-1:0]   load_mask;
    logic [XLEN-1:0]   load_top;
    logic              load_sign;
    logic [XLEN-1:0]   load_ext;

    // Both beats' lanes and data are precomputed at accept as one double-width shift;
    // the low half feeds BEAT0, the high half feeds BEAT1.
    always_comb begin
        accept       = bus.req_valid && (state == IDLE);
        req_off      = bus.req_addr[OFF_W-1:0];
        req_bytes    = 4'd1 << bus.req_size;
        req_aligned  = (req_off & OFF_W'(req_bytes - 4'd1)) == '0;
        req_cross    = (5'(req_off) + 5'(req_bytes)) > 5'(NB);
        req_bad_size = (XLEN == 32) && (bus.req_size == 2'b11);
        req_illegal  = req_bad_size || (!req_aligned && !SPLIT_EN);
        req_mask     = '0;
        for (int i = 0; i < NB; i++) begin
            req_mask[i] = (i < int'(req_bytes));
        end
        req_wide_wdata = {{XLEN{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
        req_wide_be    = {{NB{1'b0}}, req_mask} << req_off;
    end

    always_comb begin
        if (state == BEAT1) begin
            load_shifted = {bus.mem_rdata, lo_q} >> {off_q, 3'b000};
        end else begin
            load_shifted = {{XLEN{1'b0}}, bus.mem_rdata} >> {off_q, 3'b000};
        end
        load_raw   = load_shifted[XLEN-1:0];
        load_nbits = 7'd8 << size_q;
        load_mask  = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_mask[i] = (i < int'(load_nbits));
        end
        load_top  = load_mask & ~(load_mask >> 1);
        load_sign = |(load_raw & load_top);
        load_ext  = (load_raw & load_mask) | ((load_sign && !uns_q) ? ~load_mask : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_illegal ? DONE : BEAT0;
            BEAT0:   if (bus.mem_resp) state_next = split_q ? BEAT1 : DONE;
            BEAT1:   if (bus.mem_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Non-split loads finish on the first response; split loads overwrite rdata_q with the merged value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_illegal;
                split_q <= req_cross && !req_illegal;
                size_q  <= bus.req_size;
                off_q   <= req_off;
                base_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                wdata_q <= req_wide_wdata;
                be_q    <= req_wide_be;
                rdata_q <= '0;
            end
            if (state == BEAT0 && bus.mem_resp) begin
                lo_q    <= bus.mem_rdata;
                rdata_q <= load_ext;
            end
            if (state == BEAT1 && bus.mem_resp) begin
                rdata_q <= load_ext;
            end
        end
    end

    always_comb begin
        bus.req_ready       = (state == IDLE);
        bus.resp_valid      = (state == DONE);
        bus.resp_err        = (state == DONE) && err_q;
        bus.resp_rdata      = ((state == DONE) && !we_q && !err_q) ? rdata_q : '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        case (state)
            BEAT0: begin
                bus.mem_read        = !we_q;
                bus.mem_write       = we_q;
                bus.mem_addr        = base_q;
                bus.mem_byte_enable = we_q ? be_q[NB-1:0] : '1;
                bus.mem_wdata       = we_q ? wdata_q[XLEN-1:0] : '0;
            end
            BEAT1: begin
                bus.mem_read        = !we_q;
                bus.mem_write       = we_q;
                bus.mem_addr        = base_q + ADDR_W'(NB);
                bus.mem_byte_enable = we_q ? be_q[2*NB-1:NB] : '1;
                bus.mem_wdata       = we_q ? wdata_q[2*XLEN-1:XLEN] : '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rv_lsu_align.sv
// tb_rv_lsu_align: directed vector table, hand-written corner sequences and random traffic
// checked against a byte-addressed memory reference model (XLEN=32).
module tb_rv_lsu_align;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rv_lsu_align_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
    rv_lsu_align #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]  mem_bytes [logic [31:0]];
    logic [31:0] rec_addr  [$];
    logic [3:0]  rec_be    [$];
    logic [31:0] rec_wdata [$];
    logic        rec_write [$];
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    logic        got_ready_in_done;
    logic        pulse_after;
    logic        ready_after;
    logic        timed_out;
    logic        unstable;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_word;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = rd_byte(a + 32'(j));
        return w;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) mem_bytes[a + 32'(j)] = w[8*j +: 8];
    endtask

    // One full transaction; the bench plays the memory, answering each beat after 'delay' held cycles.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int delay);
        int hold;
        int wait_cyc;
        bit in_beat;
        bit done;
        rec_addr.delete();
        rec_be.delete();
        rec_wdata.delete();
        rec_write.delete();
        timed_out = 1'b0; unstable = 1'b0; got_rdata = '0; got_err = 1'b0; got_lat = 0;
        got_ready_in_done = 1'b0; pulse_after = 1'b0; ready_after = 1'b0;
        hold = 0; in_beat = 1'b0; done = 1'b0; wait_cyc = 0;
        while (!bus.req_ready && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 100 && !done; i++) begin
            bus.mem_resp = 1'b0;
            bus.mem_rdata = '0;
            if (bus.resp_valid) begin
                got_rdata = bus.resp_rdata;
                got_err = bus.resp_err;
                got_lat = i;
                got_ready_in_done = bus.req_ready;
                done = 1'b1;
            end else begin
                if (bus.mem_read || bus.mem_write) begin
                    if (!in_beat) begin
                        in_beat = 1'b1;
                        hold = 0;
                        rec_addr.push_back(bus.mem_addr);
                        rec_be.push_back(bus.mem_byte_enable);
                        rec_wdata.push_back(bus.mem_wdata);
                        rec_write.push_back(bus.mem_write);
                    end else if (bus.mem_addr !== rec_addr[$] || bus.mem_byte_enable !== rec_be[$] ||
                                 bus.mem_wdata !== rec_wdata[$]) begin
                        unstable = 1'b1;
                    end
                    if (hold == delay) begin
                        bus.mem_resp = 1'b1;
                        bus.mem_rdata = rd_word(bus.mem_addr);
                        if (bus.mem_write) begin
                            for (int j = 0; j < 4; j++)
                                if (bus.mem_byte_enable[j]) mem_bytes[bus.mem_addr + 32'(j)] = bus.mem_wdata[8*j +: 8];
                        end
                        in_beat = 1'b0;
                    end else begin
                        hold++;
                    end
                end
                @(posedge clk); #1;
            end
        end
        bus.mem_resp = 1'b0;
        if (!done) begin
            timed_out = 1'b1;
        end else begin
            @(posedge clk); #1;
            pulse_after = bus.resp_valid;
            ready_after = bus.req_ready;
        end
    endtask

    // Reference: expectations derived from byte addresses in a flat memory, not from lane shifts.
    task automatic checkModel(input string tag, input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input int delay);
        int          bytes;
        int          nb;
        logic        exp_err;
        logic [31:0] exp_val;
        logic [31:0] eb_addr [2];
        logic [3:0]  eb_be   [2];
        logic [31:0] a;
        logic [31:0] ba;
        logic [31:0] stored;
        logic [31:0] want;
        bytes = 1 << size;
        exp_err = (size == 2'd3) || (!SPLIT && (int'(addr[1:0]) % bytes) != 0);
        nb = 0;
        eb_addr[0] = '0; eb_addr[1] = '0; eb_be[0] = '0; eb_be[1] = '0;
        if (!exp_err) begin
            for (int k = 0; k < bytes; k++) begin
                a = addr + 32'(k);
                ba = {a[31:2], 2'b00};
                if (nb == 0 || eb_addr[nb-1] != ba) begin
                    eb_addr[nb] = ba;
                    nb++;
                end
                eb_be[nb-1] = eb_be[nb-1] | (4'b0001 << a[1:0]);
            end
        end
        exp_val = '0;
        if (!we && !exp_err) begin
            for (int k = 0; k < bytes; k++) exp_val = exp_val | (32'(rd_byte(addr + 32'(k))) << (8*k));
            if (!uns && bytes < 4 && exp_val[8*bytes-1]) exp_val = exp_val | ~((32'd1 << (8*bytes)) - 32'd1);
        end
        applyStimulus(we, size, uns, addr, wdata, delay);
        checkOutput({tag, "/timeout"}, 64'(timed_out), 64'(0));
        checkOutput({tag, "/err"}, 64'(got_err), 64'(exp_err));
        checkOutput({tag, "/rdata"}, 64'(got_rdata), 64'(exp_val));
        checkOutput({tag, "/latency"}, 64'(got_lat), 64'(exp_err ? 1 : nb * (delay + 1) + 1));
        checkOutput({tag, "/beats"}, 64'(rec_addr.size()), 64'(nb));
        if (rec_addr.size() == nb) begin
            for (int b = 0; b < nb; b++) begin
                checkOutput({tag, "/beat_addr"}, 64'(rec_addr[b]), 64'(eb_addr[b]));
                checkOutput({tag, "/beat_be"}, 64'(rec_be[b]), 64'(we ? eb_be[b] : 4'hF));
                checkOutput({tag, "/beat_dir"}, 64'(rec_write[b]), 64'(we));
            end
        end
        checkOutput({tag, "/stable"}, 64'(unstable), 64'(0));
        checkOutput({tag, "/ready_in_done"}, 64'(got_ready_in_done), 64'(0));
        checkOutput({tag, "/one_pulse"}, 64'(pulse_after), 64'(0));
        checkOutput({tag, "/ready_after"}, 64'(ready_after), 64'(1));
        if (we && !exp_err) begin
            stored = '0;
            want = '0;
            for (int k = 0; k < bytes; k++) begin
                stored[8*k +: 8] = rd_byte(addr + 32'(k));
                want[8*k +: 8] = wdata[8*k +: 8];
            end
            checkOutput({tag, "/stored"}, 64'(stored), 64'(want));
        end
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.mem_resp = 1'b0;

        vecs[0]  = '{"lb_103",   1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{"lbu_103",  1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'h00000080};
        vecs[2]  = '{"lh_102",   1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'hFFFF80AA};
        vecs[3]  = '{"lhu_102",  1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'h000080AA};
        vecs[4]  = '{"lw_100",   1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'h80AABBCC};
        vecs[5]  = '{"lb_100",   1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'hFFFFFFCC};
        vecs[6]  = '{"lbu_101",  1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'h80AABBCC, 1'b0, 32'h100, 4'hF, 32'h0,        32'h000000BB};
        vecs[7]  = '{"lh_pos",   1'b0, 2'd1, 1'b0, 32'h108, 32'h0,        32'h00007FFF, 1'b0, 32'h108, 4'hF, 32'h0,        32'h00007FFF};
        vecs[8]  = '{"lwu_104",  1'b0, 2'd2, 1'b1, 32'h104, 32'h0,        32'hFF00FF01, 1'b0, 32'h104, 4'hF, 32'h0,        32'hFF00FF01};
        vecs[9]  = '{"sh_102",   1'b1, 2'd1, 1'b0, 32'h102, 32'h1234,     32'h0,        1'b0, 32'h100, 4'hC, 32'h12340000, 32'h0};
        vecs[10] = '{"sb_101",   1'b1, 2'd0, 1'b0, 32'h101, 32'h5A,       32'h0,        1'b0, 32'h100, 4'h2, 32'h00005A00, 32'h0};
        vecs[11] = '{"sw_200",   1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0,        1'b0, 32'h200, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[12] = '{"ld_100",   1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[13] = '{"sd_108",   1'b1, 2'd3, 1'b0, 32'h108, 32'h55,       32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 64'(bus.req_ready), 64'(1));
        checkOutput("rst_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_rdata}), 64'(0));
        checkOutput("rst_mem", 64'({bus.mem_read, bus.mem_write, bus.mem_byte_enable}), 64'(0));
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        for (int v = 0; v < 14; v++) begin
            if (!vecs[v].exp_err) set_word(vecs[v].exp_addr, vecs[v].mem_word);
            applyStimulus(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata, 0);
            checkOutput({vecs[v].name, "/timeout"}, 64'(timed_out), 64'(0));
            checkOutput({vecs[v].name, "/err"}, 64'(got_err), 64'(vecs[v].exp_err));
            checkOutput({vecs[v].name, "/rdata"}, 64'(got_rdata), 64'(vecs[v].exp_rdata));
            checkOutput({vecs[v].name, "/latency"}, 64'(got_lat), 64'(vecs[v].exp_err ? 1 : 2));
            checkOutput({vecs[v].name, "/beats"}, 64'(rec_addr.size()), 64'(vecs[v].exp_err ? 0 : 1));
            if (!vecs[v].exp_err && rec_addr.size() == 1) begin
                checkOutput({vecs[v].name, "/addr"}, 64'(rec_addr[0]), 64'(vecs[v].exp_addr));
                checkOutput({vecs[v].name, "/be"}, 64'(rec_be[0]), 64'(vecs[v].exp_be));
                checkOutput({vecs[v].name, "/dir"}, 64'(rec_write[0]), 64'(vecs[v].we));
                if (vecs[v].we) checkOutput({vecs[v].name, "/wdata"}, 64'(rec_wdata[0]), 64'(vecs[v].exp_wdata));
            end
        end

        $display("[TB] misalignment sequences");
`ifdef MISALIGNED_SPLIT_EN
        set_word(32'h0FC, 32'h22110000);
        set_word(32'h100, 32'h00004433);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 1);
        checkOutput("lw_0fe/rdata", 64'(got_rdata), 64'(32'h44332211));
        checkOutput("lw_0fe/err", 64'(got_err), 64'(0));
        checkOutput("lw_0fe/latency", 64'(got_lat), 64'(5));
        checkOutput("lw_0fe/beats", 64'(rec_addr.size()), 64'(2));
        if (rec_addr.size() == 2) begin
            checkOutput("lw_0fe/addr0", 64'(rec_addr[0]), 64'(32'h0FC));
            checkOutput("lw_0fe/addr1", 64'(rec_addr[1]), 64'(32'h100));
        end
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 32'hA1B2C3D4, 0);
        checkOutput("sw_wrap/err", 64'(got_err), 64'(0));
        checkOutput("sw_wrap/beats", 64'(rec_addr.size()), 64'(2));
        if (rec_addr.size() == 2) begin
            checkOutput("sw_wrap/addr0", 64'(rec_addr[0]), 64'(32'hFFFFFFFC));
            checkOutput("sw_wrap/be0", 64'(rec_be[0]), 64'(4'b1000));
            checkOutput("sw_wrap/addr1", 64'(rec_addr[1]), 64'(32'h0));
            checkOutput("sw_wrap/be1", 64'(rec_be[1]), 64'(4'b0111));
        end
        checkOutput("sw_wrap/mem", 64'({rd_byte(32'h2), rd_byte(32'h1), rd_byte(32'h0), rd_byte(32'hFFFFFFFF)}),
                    64'(32'hA1B2C3D4));
        checkModel("lh_101_inbeat", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0);
`else
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0);
        checkOutput("lw_101/err", 64'(got_err), 64'(1));
        checkOutput("lw_101/latency", 64'(got_lat), 64'(1));
        checkOutput("lw_101/no_read", 64'(rec_addr.size()), 64'(0));
        checkOutput("lw_101/rdata", 64'(got_rdata), 64'(0));
        set_word(32'h300, 32'h76543210);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h303, 32'hBEEF, 0);
        checkOutput("sh_303/err", 64'(got_err), 64'(1));
        checkOutput("sh_303/no_write", 64'(rec_addr.size()), 64'(0));
        checkOutput("sh_303/mem", 64'(rd_word(32'h300)), 64'(32'h76543210));
`endif

        $display("[TB] slow memory");
        checkModel("lw_delay5", 1'b0, 2'd2, 1'b0, 32'h340, 32'h0, 5);
        checkOutput("lw_delay5/latency_abs", 64'(got_lat), 64'(7));

        $display("[TB] reset during beat");
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h400; bus.req_wdata = '0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checkOutput("rst_mid/read_before", 64'(bus.mem_read), 64'(1));
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checkOutput("rst_mid/strobes", 64'({bus.mem_read, bus.mem_write}), 64'(0));
        checkOutput("rst_mid/ready", 64'(bus.req_ready), 64'(1));
        checkOutput("rst_mid/resp", 64'(bus.resp_valid), 64'(0));
        checkOutput("rst_mid/addr", 64'(bus.mem_addr), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid || bus.mem_read || bus.mem_write || !bus.req_ready) seen = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("rst_mid/quiet", 64'(seen), 64'(0));

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            logic [31:0] base;
            logic [31:0] addr;
            base = ($urandom_range(0, 1) == 0) ? 32'h0000_0500 : 32'hFFFF_FFE0;
            addr = base + 32'($urandom_range(0, 31));
            checkModel($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
